// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//
// Sequences one operation at a time onto a shared combinational 32-bit ALU.
// Operands and opcode are registered on accept and held steady for an
// opcode-dependent number of settling cycles. This lets MUL/DIV be timed as
// multicycle paths. The 64-bit ALU result is then captured into LO/HI and
// completion is reported with a single-cycle done pulse. Illegal opcodes
// and divide-by-zero skip execution and report an error without touching
// LO/HI.
//
// Parameters:
//   MUL_CYCLES      settling cycles for opcode 1000 (1..15)
//   DIV_CYCLES      settling cycles for opcode 1001 (1..15)
// Ports:
//   in_clk          clock, rising edge
//   in_reset_n      asynchronous active-low reset
//   in_start        operation request, accepted only while out_ready=1
//   in_opcode       ALU opcode, sampled on accept
//   in_a, in_b      operands, sampled on accept
//   out_ready       high only while idle
//   out_alu_a/b     registered operands driven to the ALU
//   out_alu_opcode  registered opcode driven to the ALU
//   in_alu_result   64-bit ALU result
//   out_lo, out_hi  result registers
//   out_done        one-cycle completion pulse
//   out_error       qualifies out_done: illegal opcode or divide by zero

module alu_op_sequencer #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 8
) (
  input  logic        in_clk,
  input  logic        in_reset_n,
  input  logic        in_start,
  input  logic [3:0]  in_opcode,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_ready,
  output logic [31:0] out_alu_a,
  output logic [31:0] out_alu_b,
  output logic [3:0]  out_alu_opcode,
  input  logic [63:0] in_alu_result,
  output logic [31:0] out_lo,
  output logic [31:0] out_hi,
  output logic        out_done,
  output logic        out_error
);

  localparam logic [3:0] LP_OP_MUL     = 4'b1000;
  localparam logic [3:0] LP_OP_DIV     = 4'b1001;
  localparam logic [3:0] LP_MUL_CYCLES = 4'(MUL_CYCLES);
  localparam logic [3:0] LP_DIV_CYCLES = 4'(DIV_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DONE
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_ready;
  logic        r_done;
  logic        r_error;
  logic [31:0] r_aluA;
  logic [31:0] r_aluB;
  logic [3:0]  r_aluOpcode;
  logic [31:0] r_lo;
  logic [31:0] r_hi;

  logic        w_illegal;
  logic        w_divByZero;
  logic [3:0]  w_cycles;
  logic        w_wideResult;

  // Opcodes 1100-1111 have no ALU function behind them.
  assign w_illegal    = (in_opcode[3:2] == 2'b11);
  assign w_divByZero  = (in_opcode == LP_OP_DIV) && (in_b == 32'd0);
  // Only MUL and DIV produce a meaningful upper half worth writing to HI.
  assign w_wideResult = (r_aluOpcode == LP_OP_MUL) || (r_aluOpcode == LP_OP_DIV);

  always_comb begin
    w_cycles = 4'd1;
    if (in_opcode == LP_OP_MUL) begin
      w_cycles = LP_MUL_CYCLES;
    end else if (in_opcode == LP_OP_DIV) begin
      w_cycles = LP_DIV_CYCLES;
    end
  end

  // Single state machine. done/error are pulses: they default low every
  // cycle and are raised only on the edge that enters DONE, so they line up
  // with the freshly written LO/HI.
  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_ready     <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_aluA      <= 32'd0;
      r_aluB      <= 32'd0;
      r_aluOpcode <= 4'd0;
      r_lo        <= 32'd0;
      r_hi        <= 32'd0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (in_start) begin
            r_aluA      <= in_a;
            r_aluB      <= in_b;
            r_aluOpcode <= in_opcode;
            r_ready     <= 1'b0;
            if (w_illegal || w_divByZero) begin
              r_state <= ST_DONE;
              r_cnt   <= 4'd0;
              r_done  <= 1'b1;
              r_error <= 1'b1;
            end else begin
              r_state <= ST_EXEC;
              r_cnt   <= w_cycles;
            end
          end
        end
        ST_EXEC: begin
          r_cnt <= r_cnt - 4'd1;
          // The last settling cycle ends on the edge where cnt reads 1.
          if (r_cnt == 4'd1) begin
            r_lo <= in_alu_result[31:0];
            if (w_wideResult) begin
              r_hi <= in_alu_result[63:32];
            end
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign out_ready      = r_ready;
  assign out_done       = r_done;
  assign out_error      = r_error;
  assign out_alu_a      = r_aluA;
  assign out_alu_b      = r_aluB;
  assign out_alu_opcode = r_aluOpcode;
  assign out_lo         = r_lo;
  assign out_hi         = r_hi;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
//
// Self-checking bench for alu_op_sequencer. The bench provides its own
// behavioural ALU. It also keeps a reference of the LO/HI contents and the
// expected per-cycle handshake, derived from operation latency. Directed
// cases come first, followed by randomized operations.

module tb_alu_op_sequencer;

  localparam int MUL_N = 4;
  localparam int DIV_N = 8;

  logic        clk = 1'b0;
  logic        rstN;
  logic        start;
  logic [3:0]  opcode;
  logic [31:0] a;
  logic [31:0] b;
  logic        ready;
  logic [31:0] aluA;
  logic [31:0] aluB;
  logic [3:0]  aluOpcode;
  logic [63:0] aluResult;
  logic [31:0] lo;
  logic [31:0] hi;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;
  logic [31:0] expLo = 32'd0;
  logic [31:0] expHi = 32'd0;

  alu_op_sequencer #(
    .MUL_CYCLES(MUL_N),
    .DIV_CYCLES(DIV_N)
  ) dut (
    .in_clk        (clk),
    .in_reset_n    (rstN),
    .in_start      (start),
    .in_opcode     (opcode),
    .in_a          (a),
    .in_b          (b),
    .out_ready     (ready),
    .out_alu_a     (aluA),
    .out_alu_b     (aluB),
    .out_alu_opcode(aluOpcode),
    .in_alu_result (aluResult),
    .out_lo        (lo),
    .out_hi        (hi),
    .out_done      (done),
    .out_error     (error)
  );

  always #5 clk = ~clk;

  // Behavioural ALU. Illegal opcodes return a recognisable pattern, so any
  // write to LO/HI on the error path is visible.
  function automatic logic [63:0] aluRef(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] t;
    case (op)
      4'h0: return {32'h0, x + y};
      4'h1: return {32'h0, x - y};
      4'h2: begin t = {x, x} << y[4:0]; return {32'h0, t[63:32]}; end
      4'h3: begin t = {x, x} >> y[4:0]; return {32'h0, t[31:0]}; end
      4'h4: return {32'h0, x << y[4:0]};
      4'h5: return {32'h0, x >> y[4:0]};
      4'h6: return {32'h0, x & y};
      4'h7: return {32'h0, x | y};
      4'h8: return {32'h0, x} * {32'h0, y};
      4'h9: return (y == 32'd0) ? 64'd0 : {x % y, x / y};
      4'hA: return {32'h0, -x};
      4'hB: return {32'h0, ~x};
      default: return 64'hDEADBEEF_CAFEF00D;
    endcase
  endfunction

  assign aluResult = aluRef(aluOpcode, aluA, aluB);

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_ready"}, 64'(ready), 64'(1'b1));
    checkOutput({tag, "_done"},  64'(done),  64'(1'b0));
    checkOutput({tag, "_error"}, 64'(error), 64'(1'b0));
    checkOutput({tag, "_lo"},    64'(lo),    64'(expLo));
    checkOutput({tag, "_hi"},    64'(hi),    64'(expHi));
  endtask

  // The task issues one operation and follows it cycle by cycle until the
  // sequencer is idle again. It is entered and left at a negedge. When poke
  // is set, start is asserted with junk operands during EXEC; those requests
  // must be ignored.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y, input bit poke);
    int          n;
    bit          isErr;
    logic [63:0] res;
    checkOutput("accept_ready", 64'(ready), 64'(1'b1));
    opcode = op;
    a      = x;
    b      = y;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    isErr = (op >= 4'hC) || (op == 4'h9 && y == 32'd0);
    n     = (op == 4'h8) ? MUL_N : (op == 4'h9) ? DIV_N : 1;
    res   = aluRef(op, x, y);
    if (isErr) begin
      checkOutput("err_done",  64'(done),  64'(1'b1));
      checkOutput("err_error", 64'(error), 64'(1'b1));
      checkOutput("err_ready", 64'(ready), 64'(1'b0));
      checkOutput("err_lo",    64'(lo),    64'(expLo));
      checkOutput("err_hi",    64'(hi),    64'(expHi));
    end else begin
      for (int k = 1; k <= n; k++) begin
        checkOutput("exec_done",   64'(done),      64'(1'b0));
        checkOutput("exec_ready",  64'(ready),     64'(1'b0));
        checkOutput("exec_alu_a",  64'(aluA),      64'(x));
        checkOutput("exec_alu_b",  64'(aluB),      64'(y));
        checkOutput("exec_alu_op", 64'(aluOpcode), 64'(op));
        checkOutput("exec_lo",     64'(lo),        64'(expLo));
        checkOutput("exec_hi",     64'(hi),        64'(expHi));
        if (poke) begin
          start  = 1'b1;
          opcode = 4'($urandom);
          a      = $urandom;
          b      = $urandom;
        end
        @(posedge clk);
        @(negedge clk);
      end
      start = 1'b0;
      expLo = res[31:0];
      if (op == 4'h8 || op == 4'h9) begin
        expHi = res[63:32];
      end
      checkOutput("done_done",  64'(done),  64'(1'b1));
      checkOutput("done_error", 64'(error), 64'(1'b0));
      checkOutput("done_ready", 64'(ready), 64'(1'b0));
      checkOutput("done_lo",    64'(lo),    64'(expLo));
      checkOutput("done_hi",    64'(hi),    64'(expHi));
    end
    @(posedge clk);
    @(negedge clk);
    checkIdleOutputs("after");
    checkOutput("after_alu_a",  64'(aluA),      64'(x));
    checkOutput("after_alu_b",  64'(aluB),      64'(y));
    checkOutput("after_alu_op", 64'(aluOpcode), 64'(op));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0]  rOp;
    logic [31:0] rA;
    logic [31:0] rB;

    rstN   = 1'b0;
    start  = 1'b0;
    opcode = 4'd0;
    a      = 32'd0;
    b      = 32'd0;
    #12;
    checkIdleOutputs("reset");
    checkOutput("reset_alu_a",  64'(aluA),      64'd0);
    checkOutput("reset_alu_op", 64'(aluOpcode), 64'd0);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);

    $display("[TB] directed operations");
    applyStimulus(4'h0, 32'h0000FFFF, 32'h1, 1'b0);
    checkOutput("add_lo", 64'(lo), 64'h00010000);
    applyStimulus(4'h9, 32'h22, 32'h100, 1'b0);
    applyStimulus(4'h1, 32'h0000FFFF, 32'hFF, 1'b0);
    checkOutput("sub_lo", 64'(lo), 64'h0000FF00);
    checkOutput("sub_hi", 64'(hi), 64'h22);
    applyStimulus(4'h8, 32'h00010000, 32'h00010000, 1'b1);
    checkOutput("mul_hi", 64'(hi), 64'h1);
    checkOutput("mul_lo", 64'(lo), 64'h0);
    applyStimulus(4'h9, 32'd34, 32'd36, 1'b0);
    checkOutput("div_lo", 64'(lo), 64'd0);
    checkOutput("div_hi", 64'(hi), 64'd34);
    applyStimulus(4'h9, 32'd5, 32'd0, 1'b0);
    applyStimulus(4'hF, 32'h1234, 32'h5678, 1'b0);

    $display("[TB] reset during DIV");
    opcode = 4'h9;
    a      = 32'd100;
    b      = 32'd7;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rstN = 1'b0;
    #1;
    expLo = 32'd0;
    expHi = 32'd0;
    checkIdleOutputs("midreset");
    checkOutput("midreset_alu_a",  64'(aluA),      64'd0);
    checkOutput("midreset_alu_b",  64'(aluB),      64'd0);
    checkOutput("midreset_alu_op", 64'(aluOpcode), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("postreset_done", 64'(done), 64'(1'b0));
    end
    applyStimulus(4'h0, 32'd40, 32'd2, 1'b0);
    checkOutput("postreset_add_lo", 64'(lo), 64'd42);

    $display("[TB] randomized operations");
    for (int i = 0; i < 60; i++) begin
      rOp = 4'($urandom_range(0, 15));
      rA  = $urandom;
      rB  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      applyStimulus(rOp, rA, rB, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        checkIdleOutputs("gap");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
